// File: rtl/des_sbox_sequencer_if.sv
// Handshake and S-box lookup bundle for des_sbox_sequencer.
// master = the sequencer, slave = its environment (upstream, downstream, S-box bank).
interface des_sbox_sequencer_if;
  localparam int unsigned IN_W   = 48;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 4;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   wires_in;
  logic              sbox_req;
  logic [SEL_W-1:0]  sbox_sel;
  logic [ADDR_W-1:0] sbox_addr;
  logic [DATA_W-1:0] sbox_data;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  wires_out;
  logic              busy;

  modport master (
    input  flush, in_valid, wires_in, sbox_data, out_ready,
    output in_ready, sbox_req, sbox_sel, sbox_addr, out_valid, wires_out, busy
  );

  modport slave (
    output flush, in_valid, wires_in, sbox_data, out_ready,
    input  in_ready, sbox_req, sbox_sel, sbox_addr, out_valid, wires_out, busy
  );
endinterface

// File: rtl/des_sbox_sequencer.sv
// Serialises the eight DES S-box lookups of one round over a single shared
// lookup port and assembles the 32-bit substitution result.
module des_sbox_sequencer #(
  parameter int unsigned LOOKUP_LAT = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  des_sbox_sequencer_if.master   bus
);
  localparam int unsigned IN_W  = 48;
  localparam int unsigned OUT_W = 32;
  localparam int unsigned CNT_W = 3;
  localparam bit          LAT1  = (LOOKUP_LAT != 0);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              sbox_req_q, sbox_req_d;
  logic [2:0]        sbox_sel_q, sbox_sel_d;
  logic [5:0]        sbox_addr_q, sbox_addr_d;
  logic [OUT_W-1:0]  wires_out_q, wires_out_d;
  logic              busy_q, busy_d;

  // S-box group idx takes bits [47-6*idx -: 6]
  function automatic logic [5:0] chunk(input logic [IN_W-1:0] w, input logic [CNT_W-1:0] idx);
    return 6'(w >> (6'd42 - 6'(idx) * 6'd6));
  endfunction

  // S-box group idx lands in bits [31-4*idx -: 4]
  function automatic logic [OUT_W-1:0] put_nib(input logic [OUT_W-1:0] w,
                                               input logic [CNT_W-1:0] idx,
                                               input logic [3:0]       nib);
    logic [4:0] sh;
    sh = 5'd28 - 5'(idx) * 5'd4;
    return (w & ~(32'hF << sh)) | (32'(nib) << sh);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sbox_req_q  <= 1'b0;
      sbox_sel_q  <= '0;
      sbox_addr_q <= '0;
      wires_out_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sbox_req_q  <= sbox_req_d;
      sbox_sel_q  <= sbox_sel_d;
      sbox_addr_q <= sbox_addr_d;
      wires_out_q <= wires_out_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    wires_out_d = wires_out_q;
    sbox_sel_d  = sbox_sel_q;
    sbox_addr_d = sbox_addr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          data_d  = bus.wires_in;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // With a registered S-box the data arriving now belongs to the previous lookup
        if (!LAT1) begin
          wires_out_d = put_nib(wires_out_q, cnt_q, bus.sbox_data);
        end else if (cnt_q != '0) begin
          wires_out_d = put_nib(wires_out_q, cnt_q - 3'd1, bus.sbox_data);
        end
        if (cnt_q == 3'd7) begin
          cnt_d   = '0;
          state_d = LAT1 ? DRAIN : DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRAIN: begin
        wires_out_d = put_nib(wires_out_q, 3'd7, bus.sbox_data);
        state_d     = DONE;
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over accept, capture and output handshake
    if (bus.flush) begin
      state_d     = IDLE;
      cnt_d       = '0;
      data_d      = data_q;
      wires_out_d = wires_out_q;
    end

    sbox_req_d = (state_d == ISSUE);
    if (sbox_req_d) begin
      sbox_sel_d  = cnt_d;
      sbox_addr_d = chunk(data_d, cnt_d);
    end
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sbox_req  = sbox_req_q;
  assign bus.sbox_sel  = sbox_sel_q;
  assign bus.sbox_addr = sbox_addr_q;
  assign bus.wires_out = wires_out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed bench for des_sbox_sequencer: one instance per lookup latency,
// each served by a DES S-box table model or a sel+1 stub.
module tb_des_sbox_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_sbox_sequencer_if bus0 ();
  des_sbox_sequencer_if bus1 ();

  des_sbox_sequencer #(.LOOKUP_LAT(0)) u_dut0 (.clk(clk), .reset_n(rst_n), .bus(bus0));
  des_sbox_sequencer #(.LOOKUP_LAT(1)) u_dut1 (.clk(clk), .reset_n(rst_n), .bus(bus1));

  logic        drv_flush     [2];
  logic        drv_in_valid  [2];
  logic        drv_out_ready [2];
  logic [47:0] drv_wires_in  [2];
  bit          stub          [2];

  logic        mon_in_ready  [2];
  logic        mon_out_valid [2];
  logic        mon_sbox_req  [2];
  logic        mon_busy      [2];
  logic [2:0]  mon_sbox_sel  [2];
  logic [5:0]  mon_sbox_addr [2];
  logic [31:0] mon_wires_out [2];

  assign bus0.flush = drv_flush[0];      assign bus1.flush = drv_flush[1];
  assign bus0.in_valid = drv_in_valid[0]; assign bus1.in_valid = drv_in_valid[1];
  assign bus0.out_ready = drv_out_ready[0]; assign bus1.out_ready = drv_out_ready[1];
  assign bus0.wires_in = drv_wires_in[0]; assign bus1.wires_in = drv_wires_in[1];

  assign mon_in_ready[0] = bus0.in_ready;   assign mon_in_ready[1] = bus1.in_ready;
  assign mon_out_valid[0] = bus0.out_valid; assign mon_out_valid[1] = bus1.out_valid;
  assign mon_sbox_req[0] = bus0.sbox_req;   assign mon_sbox_req[1] = bus1.sbox_req;
  assign mon_busy[0] = bus0.busy;           assign mon_busy[1] = bus1.busy;
  assign mon_sbox_sel[0] = bus0.sbox_sel;   assign mon_sbox_sel[1] = bus1.sbox_sel;
  assign mon_sbox_addr[0] = bus0.sbox_addr; assign mon_sbox_addr[1] = bus1.sbox_addr;
  assign mon_wires_out[0] = bus0.wires_out; assign mon_wires_out[1] = bus1.wires_out;

  // Standard DES S1..S8, each stored row-major as row*16+col
  int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [3:0] sbox_model(input bit st, input logic [2:0] sel, input logic [5:0] a);
    logic [5:0] idx;
    if (st) return 4'(sel) + 4'd1;
    idx = {a[5], a[0], a[4:1]};
    return 4'(SBOX[sel][idx]);
  endfunction

  // LOOKUP_LAT=0 bank is combinational, LOOKUP_LAT=1 bank is registered
  assign bus0.sbox_data = sbox_model(stub[0], bus0.sbox_sel, bus0.sbox_addr);
  always @(posedge clk) bus1.sbox_data <= sbox_model(stub[1], bus1.sbox_sel, bus1.sbox_addr);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic send(input int k, input logic [47:0] din);
    @(negedge clk);
    drv_in_valid[k] = 1'b1;
    drv_wires_in[k] = din;
    @(negedge clk);
    drv_in_valid[k] = 1'b0;
  endtask

  // Entered at the negedge right after the accepting edge (cycle T+1)
  task automatic wait_result(input int k, input logic [47:0] din, input logic [31:0] exp,
                             input string tag, input bit do_hs);
    int cyc; int nreq; bit order_ok; bit rdy_low;
    cyc = 1; nreq = 0; order_ok = 1'b1; rdy_low = 1'b1;
    while (!mon_out_valid[k] && cyc < 40) begin
      if (mon_sbox_req[k]) begin
        if (nreq > 7 || mon_sbox_sel[k] != 3'(nreq) ||
            mon_sbox_addr[k] != 6'(din >> (42 - 6 * nreq))) order_ok = 1'b0;
        nreq++;
      end
      if (mon_in_ready[k] || !mon_busy[k]) rdy_low = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s latency", tag), 64'(cyc), 64'(9 + k));
    chk($sformatf("%s req_cycles", tag), 64'(nreq), 64'd8);
    chk($sformatf("%s lookup_order", tag), 64'(order_ok), 64'd1);
    chk($sformatf("%s in_ready_low", tag), 64'(rdy_low & ~mon_in_ready[k]), 64'd1);
    chk($sformatf("%s wires_out", tag), 64'(mon_wires_out[k]), 64'(exp));
    if (do_hs) begin
      @(negedge clk);
      chk($sformatf("%s post_hs_valid", tag), 64'(mon_out_valid[k]), 64'd0);
      chk($sformatf("%s post_hs_ready", tag), 64'(mon_in_ready[k]), 64'd1);
    end
  endtask

  typedef struct {
    int          k;
    bit          st;
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    int g;
    bit saw_ov;
    bit stable;
    vecs[0] = '{0, 1'b0, 48'h0,            32'hEFA72C4D};
    vecs[1] = '{1, 1'b1, 48'h123456789ABC, 32'h12345678};
    vecs[2] = '{0, 1'b0, 48'h000000000040, 32'hEFA72CDD};
    vecs[3] = '{0, 1'b0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[4] = '{1, 1'b0, 48'h040000000000, 32'h0FA72C4D};
    vecs[5] = '{0, 1'b1, 48'hA5A5A5A5A5A5, 32'h12345678};
    vecs[6] = '{1, 1'b0, 48'h0,            32'hEFA72C4D};

    for (int k = 0; k < 2; k++) begin
      drv_flush[k] = 1'b0; drv_in_valid[k] = 1'b0; drv_out_ready[k] = 1'b1;
      drv_wires_in[k] = '0; stub[k] = 1'b0;
    end

    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d in_ready", k), 64'(mon_in_ready[k]), 64'd0);
      chk($sformatf("rst%0d outs", k),
          64'({mon_out_valid[k], mon_sbox_req[k], mon_busy[k], mon_sbox_sel[k], mon_sbox_addr[k]}), 64'd0);
      chk($sformatf("rst%0d wires_out", k), 64'(mon_wires_out[k]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst in_ready0", 64'(mon_in_ready[0]), 64'd1);
    chk("post_rst in_ready1", 64'(mon_in_ready[1]), 64'd1);

    for (int i = 0; i < 7; i++) begin
      stub[vecs[i].k] = vecs[i].st;
      send(vecs[i].k, vecs[i].din);
      wait_result(vecs[i].k, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i), 1'b1);
    end

    // Backpressure on the LOOKUP_LAT=0 instance
    stub[0] = 1'b0;
    drv_out_ready[0] = 1'b0;
    send(0, 48'h0);
    wait_result(0, 48'h0, 32'hEFA72C4D, "bp", 1'b0);
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!mon_out_valid[0] || mon_wires_out[0] != 32'hEFA72C4D || mon_in_ready[0]) stable = 1'b0;
    end
    chk("bp hold_stable", 64'(stable), 64'd1);
    drv_out_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp release_valid", 64'(mon_out_valid[0]), 64'd0);
    chk("bp release_ready", 64'(mon_in_ready[0]), 64'd1);
    @(negedge clk);
    chk("bp single_hs", 64'({mon_out_valid[0], mon_busy[0]}), 64'd0);

    // Flush at cnt=4 with in_valid held high
    @(negedge clk);
    drv_in_valid[0] = 1'b1;
    drv_wires_in[0] = 48'hFFFFFFFFFFFF;
    g = 0; saw_ov = 1'b0;
    do begin
      @(negedge clk);
      if (mon_out_valid[0]) saw_ov = 1'b1;
      g++;
    end while (!(mon_sbox_req[0] && mon_sbox_sel[0] == 3'd4) && g < 20);
    chk("flush reached_cnt4", 64'(mon_sbox_sel[0]), 64'd4);
    drv_flush[0] = 1'b1;
    drv_wires_in[0] = 48'h000000000040;
    @(negedge clk);
    drv_flush[0] = 1'b0;
    chk("flush idle", 64'({mon_busy[0], mon_in_ready[0], mon_out_valid[0], mon_sbox_req[0]}), 64'b0100);
    chk("flush no_out_valid", 64'(saw_ov), 64'd0);
    @(negedge clk);
    drv_in_valid[0] = 1'b0;
    wait_result(0, 48'h000000000040, 32'hEFA72CDD, "after_flush", 1'b1);

    // Flush in IDLE beats a simultaneous in_valid
    @(negedge clk);
    drv_flush[0] = 1'b1; drv_in_valid[0] = 1'b1;
    @(negedge clk);
    drv_flush[0] = 1'b0; drv_in_valid[0] = 1'b0;
    chk("idle_flush not_accepted", 64'({mon_busy[0], mon_in_ready[0], mon_sbox_req[0]}), 64'b010);

    // Asynchronous reset at cnt=3 on the LOOKUP_LAT=1 instance
    stub[1] = 1'b1;
    send(1, 48'h111111111111);
    g = 0;
    while (!(mon_sbox_req[1] && mon_sbox_sel[1] == 3'd3) && g < 20) begin
      @(negedge clk); g++;
    end
    chk("rst_mid reached_cnt3", 64'(mon_sbox_sel[1]), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid outs",
        64'({mon_in_ready[1], mon_out_valid[1], mon_sbox_req[1], mon_busy[1], mon_sbox_sel[1], mon_sbox_addr[1]}), 64'd0);
    chk("rst_mid wires_out", 64'(mon_wires_out[1]), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid release_ready", 64'(mon_in_ready[1]), 64'd1);
    chk("rst_mid no_valid", 64'(mon_out_valid[1]), 64'd0);
    stub[1] = 1'b0;
    send(1, 48'h0);
    wait_result(1, 48'h0, 32'hEFA72C4D, "after_rst", 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/des_sbox_sequencer.md
Name: des_sbox_sequencer

Overview:
- Time-multiplexes one shared S-box lookup port across the eight DES substitution groups of a round.
- Accepts the 48-bit post-key-mix value and presents each 6-bit chunk to the S-box bank (S1..S8) one per cycle.
- Assembles the eight 4-bit results into the 32-bit substitution output.
- Sits between the round key-mix XOR and the P-permutation; lets one S-box mux bank serve the round datapath instead of eight parallel instances.

Parameters:
- LOOKUP_LAT, 0, S-box read latency in cycles. Legal values are 0 and 1. At 0, sbox_data is combinational from sbox_sel/sbox_addr; at 1, it is registered.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  wires_in is valid
- in_ready  output  1  block can accept wires_in
- wires_in  input  48  key-mixed value; bits 47:42 feed S1, ..., bits 5:0 feed S8
- sbox_req  output  1  lookup issued this cycle
- sbox_sel  output  3  S-box index, 0=S1 .. 7=S8
- sbox_addr  output  6  raw 6-bit S-box input chunk
- sbox_data  input  4  S-box result
- out_valid  output  1  wires_out is valid
- out_ready  input  1  downstream accepts wires_out
- wires_out  output  32  substituted value; S1 result in bits 31:28, ..., S8 result in bits 3:0
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock domain. reset_n is asynchronous assert, synchronous deassert.
- Reset forces: state=IDLE, in_ready=0 during reset then 1, out_valid=0, sbox_req=0, sbox_sel=0, sbox_addr=0, wires_out=0, busy=0, internal counter=0.
- State IDLE: in_ready=1.
  - in_valid&in_ready → latch wires_in, cnt=0, go to ISSUE.
- State ISSUE (8 cycles, cnt 0..7):
  - sbox_req=1, sbox_sel=cnt, sbox_addr=latched[47-6*cnt -: 6].
  - LOOKUP_LAT=0: capture sbox_data into nibble cnt at the end of the same cycle.
  - LOOKUP_LAT=1: capture sbox_data into nibble cnt-1 (for cnt≥1) at the end of the cycle.
  - After cnt=7: go to DONE if LOOKUP_LAT=0; go to DRAIN if LOOKUP_LAT=1.
- State DRAIN (LOOKUP_LAT=1 only, 1 cycle): sbox_req=0; capture nibble 7; go to DONE.
- State DONE:
  - out_valid=1; wires_out holds stable while out_valid&!out_ready.
  - out_valid&out_ready → go to IDLE, out_valid=0 next cycle.
- Latency: accept at cycle T → out_valid high from cycle T+9+LOOKUP_LAT.
- Throughput: one word per 10+LOOKUP_LAT cycles with out_ready tied high. in_ready is low outside IDLE; no input skid.
- In non-ISSUE states, sbox_req=0 and sbox_sel/sbox_addr hold their last values.
- wires_out is updated only by captures. It retains the last result after the DONE handshake until overwritten.
- flush:
  - In any state, next state is IDLE; out_valid, sbox_req and cnt are cleared; the partial result is discarded.
  - flush has priority over the in_valid accept and the out_ready handshake in the same cycle.
  - flush while IDLE with in_valid=1: the word is not accepted.
- reset_n asserted mid-operation: immediate return to reset values; in-flight word lost; no spurious out_valid after release.
- Capture index is always within 0..7; the counter never wraps outside ISSUE.

Test Plan:
- Standard DES table model, LOOKUP_LAT=0, wires_in=48'h0, out_ready=1 → sbox_sel 0..7 with sbox_addr=0 each cycle; wires_out=32'hEFA72C4D; out_valid exactly 9 cycles after accept.
- Stub returning sbox_sel+1, LOOKUP_LAT=1, any wires_in → wires_out=32'h12345678; out_valid 10 cycles after accept; sbox_req high exactly 8 cycles.
- S7 ordering check, standard tables: wires_in=48'h000000_000040 (bits 11:6=6'b000001) → S7 lookup addr=1 returns 13; wires_out=32'hEFA72CDD.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and wires_out stable; in_ready=0 throughout; release → one handshake, then IDLE with in_ready=1.
- flush at cnt=4, with in_valid=1 held high → next cycle IDLE, out_valid never asserted; the following accept produces the correct fresh result.
- reset_n pulsed low at cnt=3 → all outputs return to reset values asynchronously; after release, in_ready=1 and a new word completes normally.
